// File: rtl/except_ctrl_pkg.sv
// Shared exception/CP0 definitions.
// Purpose: excepttype codes, default handler vector, CP0 Status/Cause bit
// positions and the controller FSM state type. Also imported by the CP0
// register file so both agree on code values and bit layout.
package except_ctrl_pkg;

    // Handler entry PC used for every exception except eret
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

    // Codes reported to CP0 via excepttype
    localparam logic [31:0] EXC_CODE_NONE     = 32'h0000_0000;
    localparam logic [31:0] EXC_CODE_INT      = 32'h0000_0001;
    localparam logic [31:0] EXC_CODE_SYSCALL  = 32'h0000_0008;
    localparam logic [31:0] EXC_CODE_INVALID  = 32'h0000_000a;
    localparam logic [31:0] EXC_CODE_TRAP     = 32'h0000_000d;
    localparam logic [31:0] EXC_CODE_OVERFLOW = 32'h0000_000c;
    localparam logic [31:0] EXC_CODE_ERET     = 32'h0000_000e;

    // exc_vec bit positions
    localparam int unsigned EXC_VEC_W    = 5;
    localparam int unsigned EXC_SYSCALL  = 0;
    localparam int unsigned EXC_INVALID  = 1;
    localparam int unsigned EXC_TRAP     = 2;
    localparam int unsigned EXC_OVERFLOW = 3;
    localparam int unsigned EXC_ERET     = 4;

    // Status/Cause bit positions
    localparam int unsigned STATUS_IE  = 0;
    localparam int unsigned STATUS_EXL = 1;
    localparam int unsigned IM_LSB     = 8;
    localparam int unsigned IM_MSB     = 15;

    typedef enum logic [0:0] {
        StIdle,
        StDrain
    } exc_state_e;

    // An interrupt is eligible when an unmasked line is pending, interrupts
    // are globally enabled and we are not already inside a handler.
    function automatic logic int_eligible(input logic [31:0] status,
                                          input logic [31:0] cause);
        return (|(status[IM_MSB:IM_LSB] & cause[IM_MSB:IM_LSB]))
               && status[STATUS_IE] && !status[STATUS_EXL];
    endfunction

endpackage

// File: rtl/except_ctrl_if.sv
// Pipeline <-> exception controller bundle.
// Purpose: groups the MEM-stage request inputs, forwarded CP0 values and the
// controller's redirect/status outputs.
//   master : pipeline side (drives requests and CP0 values, receives results)
//   slave  : except_ctrl side
// Signals:
//   exc_vec_i     [4:0]  syscall/invalid/trap/overflow/eret requests
//   inst_valid_i         MEM holds a real instruction
//   stall_i              pipeline frozen this cycle
//   cp0_status_i/cp0_cause_i/cp0_epc_i [31:0] forwarded CP0 values
//   excepttype_o  [31:0] code to CP0
//   flush_o              squash all stages
//   new_pc_o      [31:0] redirect target
//   busy_o               controller draining
//   exc_cnt_o     [15:0] taken exception/eret count
interface except_ctrl_if;
    logic [4:0]  exc_vec_i;
    logic        inst_valid_i;
    logic        stall_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic [31:0] excepttype_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        busy_o;
    logic [15:0] exc_cnt_o;

    modport master (
        output exc_vec_i, inst_valid_i, stall_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
        input  excepttype_o, flush_o, new_pc_o, busy_o, exc_cnt_o
    );

    modport slave (
        input  exc_vec_i, inst_valid_i, stall_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
        output excepttype_o, flush_o, new_pc_o, busy_o, exc_cnt_o
    );
endinterface

// File: rtl/exc_prio_enc.sv
// Exception priority encoder (purely combinational).
// Purpose: selects exactly one excepttype code from the registered interrupt
// flag and the MEM-stage request vector.
// Ports:
//   int_pend_i        registered interrupt eligibility
//   exc_vec_i  [4:0]  request bits (syscall, invalid, trap, overflow, eret)
//   code_o     [31:0] selected code, 0 when nothing is requested
module exc_prio_enc
    import except_ctrl_pkg::*;
(
    input  logic                 int_pend_i,
    input  logic [EXC_VEC_W-1:0] exc_vec_i,
    output logic [31:0]          code_o
);

    // Interrupt outranks eret so an eret colliding with an interrupt is
    // simply re-executed after the handler returns.
    always_comb begin
        code_o = EXC_CODE_NONE;
        if (int_pend_i) begin
            code_o = EXC_CODE_INT;
        end else if (exc_vec_i[EXC_SYSCALL]) begin
            code_o = EXC_CODE_SYSCALL;
        end else if (exc_vec_i[EXC_INVALID]) begin
            code_o = EXC_CODE_INVALID;
        end else if (exc_vec_i[EXC_TRAP]) begin
            code_o = EXC_CODE_TRAP;
        end else if (exc_vec_i[EXC_OVERFLOW]) begin
            code_o = EXC_CODE_OVERFLOW;
        end else if (exc_vec_i[EXC_ERET]) begin
            code_o = EXC_CODE_ERET;
        end
    end

endmodule

// File: rtl/except_ctrl.sv
// Exception controller.
// Purpose: decides in the MEM stage whether to take an exception, interrupt
// or eret, issues a zero-latency flush/redirect, then masks further requests
// for DRAIN_CYCLES cycles while the pipeline refills.
// Ports:
//   clk  sole clock (rising edge)
//   rst  asynchronous active-low reset
//   bus  except_ctrl_if.slave: requests, CP0 values, flush/redirect outputs
// Parameters:
//   EXC_VECTOR    handler entry PC for non-eret exceptions
//   DRAIN_CYCLES  masking cycles after a redirect (1..7)
module except_ctrl
    import except_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input logic             clk,
    input logic             rst,
    except_ctrl_if.slave    bus
);

    localparam logic [2:0] DrainLoad = 3'(DRAIN_CYCLES - 1);

    exc_state_e  state_q, state_d;
    logic [2:0]  drain_cnt_q, drain_cnt_d;
    logic        int_pend_q;
    logic [15:0] exc_cnt_q, exc_cnt_d;
    logic [31:0] code;
    logic        take;

    exc_prio_enc u_prio_enc (
        .int_pend_i (int_pend_q),
        .exc_vec_i  (bus.exc_vec_i),
        .code_o     (code)
    );

    // Take decision is combinational so the flush lands in the same cycle.
    // Gated by rst so outputs read zero for the whole reset pulse.
    assign take = rst && (state_q == StIdle) && bus.inst_valid_i && !bus.stall_i
                  && (int_pend_q || (|bus.exc_vec_i));

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        exc_cnt_d   = exc_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (take) begin
                    state_d     = StDrain;
                    drain_cnt_d = DrainLoad;
                    exc_cnt_d   = exc_cnt_q + 16'd1;
                end
            end
            StDrain: begin
                // Drain runs on wall-clock cycles, independent of stall
                if (drain_cnt_q == 3'd0) begin
                    state_d = StIdle;
                end else begin
                    drain_cnt_d = drain_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d     = StIdle;
                drain_cnt_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            drain_cnt_q <= 3'd0;
            int_pend_q  <= 1'b0;
            exc_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            // Tracks CP0 every cycle, including during drain
            int_pend_q  <= int_eligible(bus.cp0_status_i, bus.cp0_cause_i);
            exc_cnt_q   <= exc_cnt_d;
        end
    end

    always_comb begin
        bus.excepttype_o = 32'h0;
        bus.flush_o      = 1'b0;
        bus.new_pc_o     = 32'h0;
        if (take) begin
            bus.excepttype_o = code;
            bus.flush_o      = 1'b1;
            bus.new_pc_o     = (code == EXC_CODE_ERET) ? bus.cp0_epc_i : EXC_VECTOR;
        end
    end

    assign bus.busy_o    = (state_q == StDrain);
    assign bus.exc_cnt_o = exc_cnt_q;

endmodule

// File: tb/tb_except_ctrl.sv
module tb_except_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    except_ctrl_if bus ();

    except_ctrl #(
        .EXC_VECTOR   (32'h0000_0020),
        .DRAIN_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_cnt;

    typedef struct {
        string       name;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [4:0]  vec;
        logic        valid;
        logic        stall;
        logic [31:0] exp_type;
        logic        exp_flush;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.exc_vec_i    = 5'b0;
        bus.inst_valid_i = 1'b0;
        bus.stall_i      = 1'b0;
        bus.cp0_status_i = 32'h0;
        bus.cp0_cause_i  = 32'h0;
        bus.cp0_epc_i    = 32'h0;
    endtask

    initial begin
        vecs[0]  = '{"int",          32'h0000_FF01, 32'h0000_0400, 32'h0, 5'b00000, 1, 0, 32'h1, 1, 32'h20};
        vecs[1]  = '{"sys+inv",      32'h0, 32'h0, 32'h0, 5'b00011, 1, 0, 32'h8, 1, 32'h20};
        vecs[2]  = '{"invalid",      32'h0, 32'h0, 32'h0, 5'b00010, 1, 0, 32'ha, 1, 32'h20};
        vecs[3]  = '{"trap",         32'h0, 32'h0, 32'h0, 5'b00100, 1, 0, 32'hd, 1, 32'h20};
        vecs[4]  = '{"overflow",     32'h0, 32'h0, 32'h0, 5'b01000, 1, 0, 32'hc, 1, 32'h20};
        vecs[5]  = '{"eret",         32'h0, 32'h0, 32'hBFC0_0100, 5'b10000, 1, 0, 32'he, 1,
                     32'hBFC0_0100};
        vecs[6]  = '{"int+eret",     32'h0000_FF01, 32'h0000_0400, 32'hBFC0_0100, 5'b10000, 1, 0,
                     32'h1, 1, 32'h20};
        vecs[7]  = '{"int_exl",      32'h0000_FF03, 32'h0000_0400, 32'h0, 5'b00000, 1, 0, 32'h0, 0, 32'h0};
        vecs[8]  = '{"int_ie0",      32'h0000_FF00, 32'h0000_0400, 32'h0, 5'b00000, 1, 0, 32'h0, 0, 32'h0};
        vecs[9]  = '{"int_masked",   32'h0000_0101, 32'h0000_0400, 32'h0, 5'b00000, 1, 0, 32'h0, 0, 32'h0};
        vecs[10] = '{"sys_novalid",  32'h0, 32'h0, 32'h0, 5'b00001, 0, 0, 32'h0, 0, 32'h0};
        vecs[11] = '{"trap_stall",   32'h0, 32'h0, 32'h0, 5'b00100, 1, 1, 32'h0, 0, 32'h0};
        vecs[12] = '{"trap+ovf",     32'h0, 32'h0, 32'h0, 5'b01100, 1, 0, 32'hd, 1, 32'h20};
        vecs[13] = '{"int+sys",      32'h0000_FF01, 32'h0000_0400, 32'h0, 5'b00001, 1, 0, 32'h1, 1, 32'h20};

        // Reset state
        rst = 1'b0;
        clear_inputs();
        exp_cnt = 16'd0;
        #1;
        check("rst_type",  bus.excepttype_o, 32'h0);
        check("rst_flush", {31'b0, bus.flush_o}, 32'h0);
        check("rst_pc",    bus.new_pc_o, 32'h0);
        check("rst_busy",  {31'b0, bus.busy_o}, 32'h0);
        check("rst_cnt",   {16'b0, bus.exc_cnt_o}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Table: CP0 values settle one cycle before the instruction arrives
        foreach (vecs[i]) begin
            @(negedge clk);
            bus.cp0_status_i = vecs[i].status;
            bus.cp0_cause_i  = vecs[i].cause;
            bus.cp0_epc_i    = vecs[i].epc;
            @(negedge clk);
            bus.exc_vec_i    = vecs[i].vec;
            bus.inst_valid_i = vecs[i].valid;
            bus.stall_i      = vecs[i].stall;
            #1;
            check({vecs[i].name, "_type"},  bus.excepttype_o, vecs[i].exp_type);
            check({vecs[i].name, "_flush"}, {31'b0, bus.flush_o}, {31'b0, vecs[i].exp_flush});
            check({vecs[i].name, "_pc"},    bus.new_pc_o, vecs[i].exp_pc);
            if (vecs[i].exp_flush) exp_cnt = exp_cnt + 16'd1;
            @(negedge clk);
            check({vecs[i].name, "_busy"}, {31'b0, bus.busy_o}, {31'b0, vecs[i].exp_flush});
            check({vecs[i].name, "_cnt"},  {16'b0, bus.exc_cnt_o}, {16'b0, exp_cnt});
            clear_inputs();
            repeat (3) @(negedge clk);
        end

        // Interrupt sync latency: no take in the cycle CP0 first shows it
        @(negedge clk);
        bus.cp0_status_i = 32'h0000_FF01;
        bus.cp0_cause_i  = 32'h0000_0400;
        bus.inst_valid_i = 1'b1;
        #1;
        check("lat_noflush", {31'b0, bus.flush_o}, 32'h0);
        @(negedge clk);
        check("lat_flush", {31'b0, bus.flush_o}, 32'h1);
        check("lat_type",  bus.excepttype_o, 32'h1);
        check("lat_pc",    bus.new_pc_o, 32'h20);
        exp_cnt = exp_cnt + 16'd1;
        @(negedge clk);
        check("lat_cnt", {16'b0, bus.exc_cnt_o}, {16'b0, exp_cnt});
        clear_inputs();
        repeat (3) @(negedge clk);

        // Drain masking: busy for 2 cycles, overflow ignored then taken
        @(negedge clk);
        bus.exc_vec_i    = 5'b00011;
        bus.inst_valid_i = 1'b1;
        #1;
        check("drn_type", bus.excepttype_o, 32'h8);
        check("drn_pc",   bus.new_pc_o, 32'h20);
        exp_cnt = exp_cnt + 16'd1;
        @(negedge clk);
        bus.exc_vec_i = 5'b01000;
        #1;
        check("drn1_busy",  {31'b0, bus.busy_o}, 32'h1);
        check("drn1_flush", {31'b0, bus.flush_o}, 32'h0);
        @(negedge clk);
        check("drn2_busy",  {31'b0, bus.busy_o}, 32'h1);
        check("drn2_flush", {31'b0, bus.flush_o}, 32'h0);
        @(negedge clk);
        check("drn3_busy",  {31'b0, bus.busy_o}, 32'h0);
        check("drn3_flush", {31'b0, bus.flush_o}, 32'h1);
        check("drn3_type",  bus.excepttype_o, 32'hc);
        exp_cnt = exp_cnt + 16'd1;
        @(negedge clk);
        check("drn_cnt", {16'b0, bus.exc_cnt_o}, {16'b0, exp_cnt});
        clear_inputs();
        repeat (3) @(negedge clk);

        // Stalled interrupt stays pending, taken on the first free cycle
        @(negedge clk);
        bus.cp0_status_i = 32'h0000_FF01;
        bus.cp0_cause_i  = 32'h0000_0400;
        bus.inst_valid_i = 1'b1;
        bus.stall_i      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_noflush", {31'b0, bus.flush_o}, 32'h0);
        end
        bus.stall_i = 1'b0;
        #1;
        check("stall_flush", {31'b0, bus.flush_o}, 32'h1);
        check("stall_type",  bus.excepttype_o, 32'h1);
        exp_cnt = exp_cnt + 16'd1;
        @(negedge clk);
        check("stall_cnt", {16'b0, bus.exc_cnt_o}, {16'b0, exp_cnt});
        clear_inputs();
        repeat (3) @(negedge clk);

        // EXL set: interrupt never taken
        bus.cp0_status_i = 32'h0000_FF03;
        bus.cp0_cause_i  = 32'h0000_0400;
        bus.inst_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("exl_noflush", {31'b0, bus.flush_o}, 32'h0);
        end
        clear_inputs();
        @(negedge clk);

        // Reset pulse mid-drain
        bus.exc_vec_i    = 5'b00001;
        bus.inst_valid_i = 1'b1;
        #1;
        check("rd_flush", {31'b0, bus.flush_o}, 32'h1);
        @(negedge clk);
        check("rd_busy", {31'b0, bus.busy_o}, 32'h1);
        #1 rst = 1'b0;
        #1;
        check("rd_r_type",  bus.excepttype_o, 32'h0);
        check("rd_r_flush", {31'b0, bus.flush_o}, 32'h0);
        check("rd_r_pc",    bus.new_pc_o, 32'h0);
        check("rd_r_busy",  {31'b0, bus.busy_o}, 32'h0);
        check("rd_r_cnt",   {16'b0, bus.exc_cnt_o}, 32'h0);
        exp_cnt = 16'd0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rd_post_flush", {31'b0, bus.flush_o}, 32'h1);
        check("rd_post_type",  bus.excepttype_o, 32'h8);
        exp_cnt = exp_cnt + 16'd1;
        @(negedge clk);
        check("rd_post_cnt", {16'b0, bus.exc_cnt_o}, {16'b0, exp_cnt});
        clear_inputs();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/except_ctrl.md
EXCEPT_CTRL -- requirements
Module: except_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'h0000_0020, handler entry PC for every non-eret exception.
REQ-002 Parameter DRAIN_CYCLES, default 2, cycles of exception masking after a redirect (legal 1..7).
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 exc_vec_i  in  5  MEM-stage requests: bit0 syscall, bit1 invalid inst, bit2 trap, bit3 overflow, bit4 eret.
REQ-006 inst_valid_i  in  1  MEM stage holds a real (non-bubble) instruction.
REQ-007 stall_i  in  1  pipeline frozen this cycle.
REQ-008 cp0_status_i / cp0_cause_i / cp0_epc_i  in  32 each  CP0 values, already forwarded from WB/CP0 writes.
REQ-009 excepttype_o  out  32  code to CP0: 1 int, 8 syscall, 'ha invalid, 'hd trap, 'hc overflow, 'he eret, 0 none.
REQ-010 flush_o  out  1  squash all pipeline stages.
REQ-011 new_pc_o  out  32  redirect target, meaningful only while flush_o=1.
REQ-012 busy_o  out  1  controller in DRAIN (exceptions masked).
REQ-013 exc_cnt_o  out  16  count of taken exceptions/erets, wraps at 16'hFFFF->0.

Function
REQ-014 Interrupt eligible when (status[15:8] & cause[15:8]) != 0, status[0]=1, status[1]=0.
REQ-015 Interrupt eligibility registered into int_pend each cycle; decisions use int_pend (1-cycle sync latency).
REQ-016 Priority: int_pend > syscall > invalid > trap > overflow > eret; exactly one code selected.
REQ-017 FSM states IDLE, DRAIN.
REQ-018 Take condition: state=IDLE, inst_valid_i=1, stall_i=0, and int_pend or any exc_vec_i bit set.
REQ-019 On take, same cycle (combinational, zero latency): excepttype_o=code, flush_o=1, new_pc_o=EXC_VECTOR, or cp0_epc_i for eret.
REQ-020 On take, next edge: state->DRAIN, drain counter loaded with DRAIN_CYCLES-1, exc_cnt_o increments.
REQ-021 Outside a take cycle: excepttype_o=0, flush_o=0, new_pc_o=0.
REQ-022 DRAIN: busy_o=1, all requests and int_pend ignored (not queued except int_pend, which keeps tracking); counter decrements each cycle regardless of stall_i; at 0 -> IDLE.
REQ-023 stall_i=1 in IDLE: no take; pending interrupt remains pending.
REQ-024 inst_valid_i=0: no take, even with int_pend=1 (interrupt waits for a real instruction so EPC is valid).
REQ-025 Interrupt and eret simultaneous: interrupt wins, eret discarded (re-executes after handler).
REQ-026 exc_vec_i bits during inst_valid_i=0 are ignored.

Reset
REQ-027 rst=0 asynchronously forces: state IDLE, drain counter 0, int_pend 0, exc_cnt_o 0, excepttype_o 0, flush_o 0, new_pc_o 0, busy_o 0.
REQ-028 Reset asserted mid-DRAIN abandons the drain; after release first take possible on first qualifying cycle.

Structure
REQ-029 Excepttype codes, EXC_VECTOR default, status/cause bit positions (IE=0, EXL=1, IM/IP=15:8) live in the shared defines package, also used by cp0 register file.
REQ-030 One sub-module exc_prio_enc (combinational priority encoder: int_pend, exc_vec -> 32-bit code); FSM, counters, output muxing in except_ctrl.

Verification
REQ-031 status=32'h0000_FF01, cause IP bit10 set, inst_valid=1 -> one cycle later excepttype_o=1, flush_o=1, new_pc_o=32'h20, exc_cnt_o=1 next edge.
REQ-032 exc_vec_i=5'b00011 (syscall+invalid), inst_valid=1 -> excepttype_o=8, new_pc_o=32'h20, busy_o=1 for 2 cycles after.
REQ-033 exc_vec_i=5'b10000, cp0_epc_i=32'hBFC0_0100 -> excepttype_o='he, new_pc_o=32'hBFC0_0100.
REQ-034 Overflow request in 1st DRAIN cycle -> no flush; same request after DRAIN ends -> excepttype_o='hc.
REQ-035 Interrupt pending with stall_i=1 for 3 cycles then 0 -> take exactly on first unstalled cycle; status[1]=1 -> never taken.
REQ-036 rst pulsed low mid-DRAIN -> all outputs 0 immediately; exc_cnt_o=0; syscall next valid cycle taken.
